piso_serial_tx: RTL
===================

Name: piso_serial_tx

Overview:
- Parallel-in, serial-out framed transmitter. It is the sending end of the serial bit-chain links built from the team's flip-flop primitives.
- Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out on a single line, framed by a start bit and a stop bit.
- Each bit is held for DIV clocks.
- Sits between a word-oriented producer and a serial link whose far end is a receiving shift chain.

Parameters:
- WIDTH, 8, data bits per frame; legal range >= 1.
- DIV, 1, clock cycles per serial bit; legal range >= 1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- din  input  WIDTH  parallel word to transmit.
- din_valid  input  1  producer indicates din is valid.
- din_ready  output  1  block can accept a word this cycle.
- so  output  1  serial output line; idles high.
- bit_stb  output  1  one-cycle pulse in the first cycle of every serial bit (start, data, stop).
- busy  output  1  high while a frame is in progress.
- done  output  1  one-cycle pulse in the last cycle of the stop bit.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - so=1, din_ready=1, busy=0, done=0, bit_stb=0.
  - FSM=IDLE; shift register, bit counter and divider counter cleared.
  - The frame in flight is abandoned, with no done pulse.
  - After rst_n deasserts, the first edge behaves as IDLE.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - din_ready=1, busy=0, so=1.
  - On an edge with din_valid & din_ready: capture din into the shift register, go to START, clear the divider.
  - din is don't-care after capture; changes during a frame are ignored.
- START:
  - so=0 for DIV cycles, then go to DATA with bit counter = WIDTH-1.
- DATA:
  - so = shift register MSB, so data leaves MSB first.
  - Each bit is held DIV cycles.
  - At the end of each bit: shift left by one and decrement the bit counter.
  - After WIDTH bits, go to STOP.
- STOP:
  - so=1 for DIV cycles.
  - done=1 in the final cycle of STOP.
  - Next state is IDLE.
- Divider counter:
  - Width is clog2(DIV), minimum 1 bit.
  - Counts 0..DIV-1 and wraps to 0 at each bit boundary.
  - With DIV=1 the counter is unused and each bit lasts exactly one cycle.
- bit_stb is 1 when the divider is 0 in START, DATA or STOP; it is 0 in IDLE.
- busy=1 in START, DATA and STOP; din_ready = ~busy.
- Timing:
  - Frame length is (WIDTH+2)*DIV cycles.
  - The first start-bit cycle is the cycle after the handshake edge.
  - Back-to-back frames have exactly one IDLE cycle (so=1) between the stop bit and the next start bit.
- All outputs are registered or decoded from registered state only. There is no combinational path from din/din_valid to any output.
- din_valid while busy: no effect. The producer holds the word until din_ready.
- Illegal parameters (WIDTH<1 or DIV<1): elaboration-time error.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles, then release -> so=1, din_ready=1, busy=0, done=0, bit_stb=0. With din_valid=0 for 10 cycles, nothing changes.
- Single frame, WIDTH=8, DIV=1, din=8'hA5, one-cycle valid -> so over cycles 1..10 = 0,1,0,1,0,0,1,0,1,1. bit_stb high in all 10 cycles. done high in cycle 10 only. busy high in cycles 1..10. din_ready high again in cycle 11.
- DIV=3, din=8'h81 -> each level held 3 cycles: 0x3, 1x3, 0x18, 1x3, 1x3. Frame is 30 cycles. bit_stb fires every 3rd cycle, 10 pulses total.
- Back-to-back: din_valid held high with 8'hFF then 8'h00 -> the two frames are separated by exactly one so=1 IDLE cycle. The second word is accepted only on the IDLE edge. Changing din mid-frame does not alter the first frame.
- Reset mid-frame: assert rst_n=0 asynchronously during DATA bit 4 of 8'h00 -> so goes to 1 before the next clk edge, busy=0, no done pulse. After release, a new frame with 8'h3C transmits correctly.
- Edge width, WIDTH=1, DIV=1, din=1'b0 -> so = 0,0,1 over 3 cycles. done is high in cycle 3.

Source files
------------

// File: rtl/piso_serial_tx.sv
// Framed parallel-in/serial-out transmitter: start bit (0), WIDTH data bits MSB first, stop bit (1).
// Each serial bit is held for DIV clocks. All outputs come straight from flops.
module piso_serial_tx #(
  parameter int WIDTH = 8,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             so,
  output logic             bit_stb,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  if (WIDTH < 1 || DIV < 1) begin : g_bad_params
    $error("piso_serial_tx: WIDTH and DIV must both be >= 1");
  end

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // Handshake: a word moves on a rising edge where din_valid and din_ready are both high.
  // din_ready is low for the whole frame; the producer must hold din until it is accepted.
  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    div_q, div_d;
  logic             so_q, so_d;
  logic             stb_q, stb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_end;

  assign bit_end = (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    case (state_q)
      S_IDLE: begin
        if (din_valid && !busy_q) begin
          state_d = S_START;
          sr_d    = din;
          div_d   = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          cnt_d   = CNT_LAST;
          div_d   = '0;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          div_d = '0;
          sr_d  = sr_q << 1;
          if (cnt_q == '0) begin
            state_d = S_STOP;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          div_d   = '0;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so that they are registered yet cycle-aligned.
  always_comb begin
    so_d   = 1'b1;
    if (state_d == S_START) so_d = 1'b0;
    if (state_d == S_DATA)  so_d = sr_d[WIDTH-1];
    busy_d = (state_d != S_IDLE);
    stb_d  = (state_d != S_IDLE) && (div_d == '0);
    done_d = (state_d == S_STOP) && (div_d == DIV_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      div_q   <= '0;
      so_q    <= 1'b1;
      stb_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      so_q    <= so_d;
      stb_q   <= stb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign so        = so_q;
  assign bit_stb   = stb_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign din_ready = ~busy_q;
  assign dbg_state = state_q;

endmodule
